// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one single-port dcache among CORES HLS requesters.
// Read data is steered back to the issuing core through an in-order tag FIFO.
module dcache_port_arbiter #(
   parameter int CORES  = 4,
   parameter int DEPTH  = 256,
   parameter int DBITS  = 32,
   parameter int ABITS  = $clog2(DEPTH),
   parameter int RD_LAT = 3,
   parameter int TAGS   = RD_LAT + 1
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        en,
   input  logic [CORES-1:0]            req_ce,
   input  logic [CORES-1:0]            req_we,
   input  logic [3:0]                  req_mask [CORES],
   input  logic [ABITS-1:0]            req_addr [CORES],
   input  logic [DBITS-1:0]            req_d    [CORES],
   output logic [CORES-1:0]            req_ready,
   output logic [DBITS-1:0]            rsp_q    [CORES],
   output logic [CORES-1:0]            rsp_vld,
   output logic                        mem_ce,
   output logic                        mem_we,
   output logic [3:0]                  mem_mask,
   output logic [ABITS-1:0]            mem_addr,
   output logic [DBITS-1:0]            mem_d,
   input  logic                        mem_ready,
   input  logic [DBITS-1:0]            mem_q,
   input  logic                        mem_q_vld,
   output logic                        err_underflow,
   output logic [$clog2(TAGS+1)-1:0]   outstanding
);

   localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;
   localparam int TW = (TAGS > 1) ? $clog2(TAGS) : 1;
   localparam int CW = $clog2(TAGS + 1);

   // Handshake: request i transfers in a cycle where req_ce[i] & req_ready[i].
   // req_ready is combinational from the same-cycle req_ce, en, mem_ready and
   // FIFO state; mem_ce is raised only in such a cycle, so every mem_ce is
   // accepted downstream (mem_ready already high). Read data comes back on
   // mem_q_vld in issue order and leaves as a one-cycle rsp_vld strobe.

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] rr_next;
   logic [PW-1:0] tag_mem [TAGS];
   logic [TW-1:0] wr_ptr;
   logic [TW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [PW-1:0] head_tag;
   logic [PW-1:0] winner;
   logic          found;
   logic          grant;
   logic          push;
   logic          pop;
   logic          can_push;
   logic          fifo_empty;
   logic          fifo_full;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(TAGS - 1)) ? '0 : p + TW'(1);
   endfunction

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == CW'(TAGS));
   assign head_tag    = tag_mem[rd_ptr];
   assign pop         = en & mem_q_vld & ~fifo_empty;
   // A read may take the slot being freed by a same-cycle pop.
   assign can_push    = ~fifo_full | pop;
   assign outstanding = count;

   always_comb begin
      int            idx;
      logic [PW-1:0] cand;
      idx    = 0;
      cand   = '0;
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < CORES; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= CORES) idx = idx - CORES;
         cand = PW'(idx);
         if (!found && req_ce[cand] && (req_we[cand] || can_push)) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // rstn gates the grant so the downstream strobe drops as soon as reset asserts.
   assign grant   = rstn & en & mem_ready & found;
   assign push    = grant & ~req_we[winner];
   assign rr_next = (winner == PW'(CORES - 1)) ? '0 : winner + PW'(1);

   always_comb begin
      req_ready = '0;
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_mask  = '0;
      mem_addr  = '0;
      mem_d     = '0;
      if (grant) begin
         req_ready[winner] = 1'b1;
         mem_ce            = 1'b1;
         mem_we            = req_we[winner];
         mem_mask          = req_mask[winner];
         mem_addr          = req_addr[winner];
         mem_d             = req_d[winner];
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= winner;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr        <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rsp_vld       <= '0;
         err_underflow <= 1'b0;
         for (int i = 0; i < CORES; i++) rsp_q[i] <= '0;
      end else begin
         rsp_vld <= '0;
         if (grant) rr_ptr <= rr_next;
         if (push) wr_ptr <= tag_inc(wr_ptr);
         if (pop) begin
            rd_ptr            <= tag_inc(rd_ptr);
            rsp_q[head_tag]   <= mem_q;
            rsp_vld[head_tag] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (en && mem_q_vld && fifo_empty) err_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomized and directed bench for dcache_port_arbiter with a fixed-latency
// cache model and a grant-order reference scoreboard.
module tb_dcache_port_arbiter;

   localparam int CORES  = 4;
   localparam int DEPTH  = 256;
   localparam int DBITS  = 32;
   localparam int ABITS  = 8;
   localparam int RD_LAT = 3;
   localparam int TAGS   = RD_LAT + 1;
   localparam int CW     = $clog2(TAGS + 1);

   logic              clk  = 1'b0;
   logic              rstn = 1'b0;
   logic              en   = 1'b0;
   logic [CORES-1:0]  req_ce;
   logic [CORES-1:0]  req_we;
   logic [3:0]        req_mask [CORES];
   logic [ABITS-1:0]  req_addr [CORES];
   logic [DBITS-1:0]  req_d    [CORES];
   logic [CORES-1:0]  req_ready;
   logic [DBITS-1:0]  rsp_q    [CORES];
   logic [CORES-1:0]  rsp_vld;
   logic              mem_ce;
   logic              mem_we;
   logic [3:0]        mem_mask;
   logic [ABITS-1:0]  mem_addr;
   logic [DBITS-1:0]  mem_d;
   logic              mem_ready = 1'b0;
   logic [DBITS-1:0]  mem_q;
   logic              mem_q_vld;
   logic              err_underflow;
   logic [CW-1:0]     outstanding;

   int n_checks = 0;
   int n_fail   = 0;

   dcache_port_arbiter #(
      .CORES(CORES), .DEPTH(DEPTH), .DBITS(DBITS), .ABITS(ABITS),
      .RD_LAT(RD_LAT), .TAGS(TAGS)
   ) dut (
      .clk(clk), .rstn(rstn), .en(en),
      .req_ce(req_ce), .req_we(req_we), .req_mask(req_mask),
      .req_addr(req_addr), .req_d(req_d), .req_ready(req_ready),
      .rsp_q(rsp_q), .rsp_vld(rsp_vld),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_mask(mem_mask),
      .mem_addr(mem_addr), .mem_d(mem_d), .mem_ready(mem_ready),
      .mem_q(mem_q), .mem_q_vld(mem_q_vld),
      .err_underflow(err_underflow), .outstanding(outstanding)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- cache model (fixed latency, stalls on en low) ----------------
   logic [7:0]       cache_mem [DEPTH];
   logic             pipe_v [RD_LAT];
   logic [DBITS-1:0] pipe_d [RD_LAT];
   logic             inject_vld = 1'b0;

   assign mem_q_vld = pipe_v[RD_LAT-1] | inject_vld;
   assign mem_q     = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'h5A5A_A5A5;

   initial begin
      logic [DBITS-1:0] rd;
      for (int i = 0; i < DEPTH; i++) cache_mem[i] = 8'h00;
      for (int s = 0; s < RD_LAT; s++) begin
         pipe_v[s] = 1'b0;
         pipe_d[s] = '0;
      end
      forever begin
         @(posedge clk);
         if (en) begin
            for (int b = 0; b < 4; b++) rd[8*b +: 8] = cache_mem[(int'(mem_addr) + b) % DEPTH];
            if (mem_ce && mem_we)
               for (int b = 0; b < 4; b++)
                  if (mem_mask[b]) cache_mem[(int'(mem_addr) + b) % DEPTH] <= mem_d[8*b +: 8];
            pipe_v[0] <= mem_ce && !mem_we;
            pipe_d[0] <= rd;
            for (int s = 1; s < RD_LAT; s++) begin
               pipe_v[s] <= pipe_v[s-1];
               pipe_d[s] <= pipe_d[s-1];
            end
         end
      end
   end

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [7:0]       ref_mem [DEPTH];
   logic [DBITS-1:0] exp_q [$];    // expected read data, grant order
   int               tag_q [$];    // issuing core, grant order
   int               m_rr;
   logic             m_err;
   logic [CORES-1:0] exp_rsp;
   int               exp_core;
   logic [DBITS-1:0] exp_data;

   function automatic logic [DBITS-1:0] ref_word(input logic [ABITS-1:0] a);
      logic [DBITS-1:0] w;
      for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[(int'(a) + b) % DEPTH];
      return w;
   endfunction

   initial begin
      int   w;
      bit   pop;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      m_rr = 0; m_err = 1'b0; exp_rsp = '0; exp_core = 0; exp_data = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            m_rr = 0; m_err = 1'b0; exp_rsp = '0;
            exp_q.delete();
            tag_q.delete();
            check("rst_req_ready", req_ready, 0);
            check("rst_mem_ce", mem_ce, 0);
            check("rst_rsp_vld", rsp_vld, 0);
            check("rst_outstanding", outstanding, 0);
            check("rst_err", err_underflow, 0);
            continue;
         end
         // responses produced by the previous cycle's pop
         check("rsp_vld", rsp_vld, exp_rsp);
         if (exp_rsp != '0) check("rsp_q", rsp_q[exp_core], exp_data);
         check("outstanding", outstanding, tag_q.size());
         check("err_underflow", err_underflow, m_err);

         pop = en && mem_q_vld && (tag_q.size() > 0);
         w = -1;
         if (en && mem_ready)
            for (int k = 0; k < CORES; k++) begin
               int c;
               c = (m_rr + k) % CORES;
               if (w < 0 && req_ce[c] && (req_we[c] || tag_q.size() < TAGS || pop)) w = c;
            end

         check("req_ready", req_ready, (w >= 0) ? (64'd1 << w) : 64'd0);
         check("mem_ce", mem_ce, w >= 0);
         if (w >= 0) begin
            check("mem_we", mem_we, req_we[w]);
            check("mem_addr", mem_addr, req_addr[w]);
            check("mem_mask", mem_mask, req_mask[w]);
            check("mem_d", mem_d, req_d[w]);
         end else begin
            check("mem_idle", {mem_we, mem_mask, mem_addr, mem_d}, 0);
         end

         exp_rsp = '0;
         if (pop) begin
            exp_core = tag_q.pop_front();
            exp_data = exp_q.pop_front();
            exp_rsp[exp_core] = 1'b1;
         end else if (en && mem_q_vld) begin
            m_err = 1'b1;
         end
         if (w >= 0) begin
            if (req_we[w]) begin
               for (int b = 0; b < 4; b++)
                  if (req_mask[w][b]) ref_mem[(int'(req_addr[w]) + b) % DEPTH] = req_d[w][8*b +: 8];
            end else begin
               tag_q.push_back(w);
               exp_q.push_back(ref_word(req_addr[w]));
            end
            m_rr = (w + 1) % CORES;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      req_ce = '0;
      req_we = '0;
      for (int c = 0; c < CORES; c++) begin
         req_mask[c] = '0;
         req_addr[c] = '0;
         req_d[c]    = '0;
      end
   endtask

   task automatic set_req(input int c, input logic we, input logic [ABITS-1:0] a,
                          input logic [DBITS-1:0] d, input logic [3:0] m);
      req_ce[c]   = 1'b1;
      req_we[c]   = we;
      req_addr[c] = a;
      req_d[c]    = d;
      req_mask[c] = m;
   endtask

   task automatic rand_reqs();
      for (int c = 0; c < CORES; c++) begin
         req_ce[c]   = ($urandom_range(0, 99) < 60);
         req_we[c]   = ($urandom_range(0, 2) == 0);
         req_addr[c] = ABITS'($urandom_range(0, 15) * 4);
         req_d[c]    = $urandom;
         req_mask[c] = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      drive_idle();
      step(3);
      rstn = 1'b1; en = 1'b1; mem_ready = 1'b1;
      step(1);

      // core 0 write then read back
      set_req(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF); step(1);
      drive_idle(); set_req(0, 1'b0, 8'h10, '0, 4'h0); step(1);
      drive_idle(); step(6);

      // align pointer to 0, then all cores read for 8 cycles
      set_req(3, 1'b1, 8'h20, 32'h0BAD_F00D, 4'hF); step(1);
      drive_idle();
      for (int c = 0; c < CORES; c++) set_req(c, 1'b0, ABITS'(16 + 4 * c), '0, 4'h0);
      step(8);
      drive_idle(); step(6);

      // pointer to 2, then core 1 write races core 2 read on the same word
      set_req(1, 1'b1, 8'h30, 32'h1111_2222, 4'hF); step(1);
      drive_idle();
      set_req(1, 1'b1, 8'h30, 32'h3333_4444, 4'hF);
      set_req(2, 1'b0, 8'h30, '0, 4'h0);
      step(1);
      drive_idle(); set_req(1, 1'b1, 8'h30, 32'h3333_4444, 4'hF); step(1);
      drive_idle(); set_req(2, 1'b0, 8'h30, '0, 4'h0); step(1);
      drive_idle(); step(6);

      // downstream back-pressure under load
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin rand_reqs(); step(1); end
      mem_ready = 1'b1;
      drive_idle();
      for (int c = 0; c < CORES; c++) set_req(c, 1'b0, ABITS'(4 * c), '0, 4'h0);
      step(4);
      drive_idle(); step(6);

      // three reads outstanding, then en dropped for 3 cycles
      for (int c = 0; c < 3; c++) set_req(c, 1'b0, ABITS'(16 + 4 * c), '0, 4'h0);
      step(3);
      drive_idle(); en = 1'b0; step(3);
      en = 1'b1; step(6);

      // response with nothing outstanding
      inject_vld = 1'b1; step(1);
      inject_vld = 1'b0; step(3);

      // random traffic with an asynchronous reset in the middle
      for (int i = 0; i < 300; i++) begin
         rand_reqs();
         en        = ($urandom_range(0, 9) != 0);
         mem_ready = ($urandom_range(0, 9) < 8);
         if (i == 150) begin
            #2 rstn = 1'b0;
            #1;
            check("async_rst_req_ready", req_ready, 0);
            check("async_rst_mem_ce", {mem_ce, mem_we, mem_mask, mem_addr, mem_d}, 0);
            check("async_rst_rsp_vld", rsp_vld, 0);
            check("async_rst_outstanding", outstanding, 0);
            check("async_rst_err", err_underflow, 0);
            for (int c = 0; c < CORES; c++) check("async_rst_rsp_q", rsp_q[c], 0);
         end
         if (i == 152) rstn = 1'b1;
         step(1);
      end

      // drain
      drive_idle(); en = 1'b1; mem_ready = 1'b1;
      step(10);
      check("drain_exp_q", exp_q.size(), 0);
      check("drain_outstanding", outstanding, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Round-robin arbiter that shares one single-port data-cache interface (ap_memory style, byte-masked writes, fixed-latency read return with valid) among CORES HLS requesters. It grants at most one request per cycle. It routes each read response back to the issuing core using an in-order tag FIFO. It sits between the per-core HLS dcache ports and one cache/cache-model port.

## Interface
- CORES, 4, number of requesters (≥2)
- DEPTH, 256, cache address space in bytes
- DBITS, 32, data width
- ABITS, $clog2(DEPTH), address width
- RD_LAT, 3, cycles from accepted read to downstream mem_q_vld
- TAGS, RD_LAT+1, tag FIFO depth (max outstanding reads)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  global clock-enable; the parent also wires it to the cache's hls_ap_ce
- req_ce  in  [CORES]  request valid
- req_we  in  [CORES]  1 = write, 0 = read
- req_mask  in  4 [CORES]  byte write mask
- req_addr  in  ABITS [CORES]  byte address
- req_d  in  DBITS [CORES]  write data
- req_ready  out  [CORES]  grant; request accepted when req_ce & req_ready
- rsp_q  out  DBITS [CORES]  read data
- rsp_vld  out  [CORES]  one-cycle read-data strobe
- mem_ce, mem_we  out  1  downstream strobe / write
- mem_mask  out  4  downstream byte mask
- mem_addr  out  ABITS  downstream address
- mem_d  out  DBITS  downstream write data
- mem_ready  in  1  downstream can accept
- mem_q  in  DBITS  downstream read data
- mem_q_vld  in  1  downstream read-data valid
- err_underflow  out  1  sticky: mem_q_vld seen with tag FIFO empty
- outstanding  out  $clog2(TAGS+1)  reads in flight

## Operation
- Round-robin pointer rr_ptr (reset 0). Winner = first i with req_ce[i], scanning rr_ptr, rr_ptr+1, … mod CORES.
- A read is eligible only when the FIFO is not full, or when a pop happens in the same cycle. Writes are always eligible. An ineligible read is skipped and the scan continues to the next requester.
- Grant condition: en & mem_ready & eligible winner exists. In that case req_ready[winner]=1 and all other req_ready bits are 0. Grant is combinational.
- The mem_* outputs are a combinational mux of the winner's request. mem_ce=1 only on a grant. When there is no grant, mem_ce=0 and the other mem_* outputs are don't-care (driven 0).
- On a grant, rr_ptr ← (winner+1) mod CORES. Without a grant, rr_ptr holds.
- On a read grant, push the winner index into the tag FIFO.
- mem_q_vld & en: pop the head tag t, and register rsp_q[t] ← mem_q and rsp_vld[t] ← 1 for one cycle. All other rsp_vld bits are 0.
- A push and a pop in the same cycle are both performed, and the count is unchanged.
- mem_q_vld with an empty FIFO: no pop, no rsp_vld, err_underflow ← 1 (cleared only by reset).
- en=0: no grants, mem_ce=0, and rr_ptr, FIFO and rsp_q all hold. rsp_vld is forced to 0, and mem_q_vld is ignored.
- Index arithmetic is modulo CORES / TAGS. outstanding = FIFO count, ranging 0..TAGS.

## Timing
- Reset values: req_ready=0, rsp_q=0, rsp_vld=0, mem_* outputs=0, err_underflow=0, outstanding=0, rr_ptr=0, FIFO empty.
- Reset asserted mid-operation discards all in-flight tags. Responses arriving after reset release hit an empty FIFO and set err_underflow.
- Read granted in cycle T → mem_q_vld in cycle T+RD_LAT (with en high throughout) → rsp_vld[core] in cycle T+RD_LAT+1.
- A write is complete in its grant cycle and produces no response.
- Throughput is 1 grant per cycle. With TAGS = RD_LAT+1, back-to-back reads never stall on FIFO full.
- Responses return in grant order.

## Test plan
- Single core 0 reads addr 0x10 after writing 0xDEADBEEF with mask 0xF → req_ready[0] in the same cycle as each request; rsp_vld[0] 4 cycles after the read grant with rsp_q[0]=0xDEADBEEF.
- All 4 cores hold req_ce (reads) continuously for 8 cycles → grants are 0,1,2,3,0,1,2,3; each core receives exactly 2 rsp_vld, in order; outstanding never exceeds 4.
- Core 1 writes and core 2 reads the same cycle with rr_ptr=2 → core 2 is granted first, core 1 in the next cycle; core 2's response carries the old data.
- Hold mem_ready=0 for 5 cycles under load → no req_ready and no mem_ce; rr_ptr is unchanged; grants resume at the same pointer.
- Drop en for 3 cycles with 3 reads outstanding → no rsp_vld and no grants; after en returns, the 3 responses arrive at the correct cores in order.
- Inject mem_q_vld with the FIFO empty → err_underflow=1 and stays 1; no rsp_vld. Asserting rstn low mid-traffic → all outputs return to their reset values asynchronously.
